// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

  // Operand width used when the instantiating level does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Control FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_negate.sv
// Conditional two's-complement negate of a WIDTH-bit vector.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module mult_negate #(
  parameter int WIDTH = 8
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Invert-and-increment when neg is set. The most negative input maps onto
  // itself, which read as unsigned is exactly the wanted magnitude 2^(WIDTH-1).
  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/seq_mult.sv
// Radix-2 shift-add multiplier, unsigned or two's-complement, full 2*WIDTH product.
// Latency: done pulses WIDTH edges after the sampling edge (WIDTH+1 counting it); one result per WIDTH+2 cycles.
// Backpressure: none; start is only honoured in IDLE and ignored while busy.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_flag;
  logic [2*WIDTH-1:0] prod_fix;

  // Operand magnitudes; only negated when the operand is negative in signed mode.
  mult_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg  (signed_mode & a[WIDTH-1]),
    .din  (a),
    .dout (a_mag)
  );

  mult_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg  (signed_mode & b[WIDTH-1]),
    .din  (b),
    .dout (b_mag)
  );

  // Accumulator value after the current multiplier bit is folded in.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  // Sign-corrected final product, taken from the accumulator's last update so
  // p can be loaded on the same edge that finishes the last RUN cycle.
  mult_negate #(.WIDTH(2*WIDTH)) u_neg_p (
    .neg  (neg_flag),
    .din  (acc_nxt),
    .dout (prod_fix)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on start, one shift-add step per RUN cycle,
  // and capture the corrected product on the final step. p is otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      neg_flag <= 1'b0;
      p        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            neg_flag <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            p <= prod_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult at WIDTH=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .p           (p)
  );

  // Run one operation from IDLE. edges counts rising edges starting with the
  // sampling edge as 1, up to the edge after which done is seen. Operands are
  // scrambled right after sampling. One extra edge is stepped afterwards so
  // the DUT is back in IDLE on return; done/p at that point are reported too.
  task automatic run_op(input logic sm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output logic [2*W-1:0] prod, output int edges,
                        output logic done_after, output logic [2*W-1:0] prod_after);
    @(negedge clk);
    signed_mode = sm;
    a           = aa;
    b           = bb;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    a           = ~aa;
    b           = 8'h5A;
    signed_mode = ~sm;
    edges       = 1;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    prod = p;
    @(posedge clk);
    #1;
    done_after = done;
    prod_after = p;
  endtask

  task automatic test_reset();
    int edges;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    vectors++;
    if (p !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_p: got %h want 0000", p);
    end
    // Start presented on the very edge after reset is released.
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    a     = 8'd3;
    b     = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_after_reset_busy: got %b want 1", busy);
    end
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    vectors++;
    if (p !== 16'd15 || edges != 9) begin
      miscompares++;
      $display("FAIL start_after_reset_result: got p=%h edges=%0d want p=000f edges=9", p, edges);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_after;
    logic           done_after;
    int             edges;
    run_op(1'b0, 8'd8, 8'd8, prod, edges, done_after, prod_after);
    vectors++;
    if (prod !== 16'h0040) begin
      miscompares++;
      $display("FAIL basic_8x8_p: got %h want 0040", prod);
    end
    vectors++;
    if (edges != 9) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d edges want 9", edges);
    end
    vectors++;
    if (done_after !== 1'b0) begin
      miscompares++;
      $display("FAIL done_single_cycle: got %b want 0", done_after);
    end
    vectors++;
    if (prod_after !== 16'h0040 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL p_hold_idle: got p=%h busy=%b want p=0040 busy=0", prod_after, busy);
    end
  endtask

  typedef struct {
    logic           sm;
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic test_vectors();
    vec_t           tbl[7];
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_after;
    logic           done_after;
    int             edges;
    tbl[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};  // 255*255 = 65025
    tbl[1] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};  // -1*-1
    tbl[2] = '{1'b1, 8'h80, 8'h80, 16'h4000};  // -128*-128 = 16384
    tbl[3] = '{1'b1, 8'hFB, 8'h03, 16'hFFF1};  // -5*3 = -15
    tbl[4] = '{1'b1, 8'h7F, 8'h80, 16'hC080};  // 127*-128 = -16256
    tbl[5] = '{1'b1, 8'h80, 8'h01, 16'hFF80};  // -128*1
    tbl[6] = '{1'b0, 8'h00, 8'hAB, 16'h0000};  // zero operand, full latency
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].sm, tbl[i].va, tbl[i].vb, prod, edges, done_after, prod_after);
      vectors++;
      if (prod !== tbl[i].exp || edges != 9) begin
        miscompares++;
        $display("FAIL vector_%0d sm=%b %h*%h: got p=%h edges=%0d want p=%h edges=9",
                 i, tbl[i].sm, tbl[i].va, tbl[i].vb, prod, edges, tbl[i].exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    int             edges;
    int             done_cnt;
    int             done_edge;
    logic [2*W-1:0] prod;
    done_cnt  = 0;
    done_edge = 0;
    prod      = 'x;
    @(negedge clk);
    signed_mode = 1'b0;
    a           = 8'h13;
    b           = 8'h37;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start       = (i == 2);
      a           = 8'hFF;
      b           = 8'hFF;
      signed_mode = 1'b1;
      @(posedge clk);
      #1;
      edges++;
      if (done) begin
        done_cnt++;
        done_edge = edges;
        prod      = p;
      end
    end
    start = 1'b0;
    vectors++;
    if (prod !== 16'h0415 || done_edge != 9) begin
      miscompares++;
      $display("FAIL start_mid_run_result: got p=%h edge=%0d want p=0415 edge=9", prod, done_edge);
    end
    vectors++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_mid_run_pulses: got %0d pulses busy=%b want 1 pulse busy=0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_midrun();
    int             done_cnt;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_after;
    logic           done_after;
    int             edges;
    done_cnt = 0;
    @(negedge clk);
    signed_mode = 1'b0;
    a           = 8'h2C;
    b           = 8'h6A;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (p !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got p=%h busy=%b done=%b want p=0000 busy=0 done=0", p, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    vectors++;
    if (done_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_abandon_no_done: got %0d pulses want 0", done_cnt);
    end
    run_op(1'b0, 8'h2C, 8'h6A, prod, edges, done_after, prod_after);
    vectors++;
    if (prod !== 16'h1238 || edges != 9) begin
      miscompares++;
      $display("FAIL restart_after_reset: got p=%h edges=%0d want p=1238 edges=9", prod, edges);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   opa[3];
    logic [W-1:0]   opb[3];
    logic [2*W-1:0] exp[3];
    logic [2*W-1:0] got_p[3];
    int             got_e[3];
    int             idx;
    int             ge;
    opa[0] = 8'h13; opb[0] = 8'h37; exp[0] = 16'h0415;  // 19*55   = 1045
    opa[1] = 8'h2C; opb[1] = 8'h6A; exp[1] = 16'h1238;  // 44*106  = 4664
    opa[2] = 8'hDA; opb[2] = 8'h56; exp[2] = 16'h493C;  // 218*86  = 18748
    for (int i = 0; i < 3; i++) begin
      got_p[i] = 'x;
      got_e[i] = 0;
    end
    idx = 0;
    ge  = 0;
    @(negedge clk);
    signed_mode = 1'b0;
    a           = opa[0];
    b           = opb[0];
    start       = 1'b1;
    while (idx < 3 && ge < 60) begin
      @(posedge clk);
      #1;
      ge++;
      if (done) begin
        got_p[idx] = p;
        got_e[idx] = ge;
        idx++;
        if (idx < 3) begin
          a = opa[idx];
          b = opb[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got_p[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL back_to_back_p%0d: got %h want %h", i, got_p[i], exp[i]);
      end
    end
    vectors++;
    if (got_e[0] != 9 || got_e[1] - got_e[0] != 10 || got_e[2] - got_e[1] != 10) begin
      miscompares++;
      $display("FAIL back_to_back_spacing: got done at edges %0d,%0d,%0d want 9,19,29",
               got_e[0], got_e[1], got_e[2]);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
